// File: rtl/int_window_packer.sv
// int_window_packer
// Collects a stream of integer samples into fixed-size groups of NUM_INPUTS
// lanes and presents each completed group as one wide word. A group may be
// cut short with s_last; unused upper lanes of a short group are zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// EMPTY | no samples held for the current group (cnt == 0)
// FILL  | cnt samples already stored in fill lanes 0..cnt-1 (cnt > 0)
module int_window_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic                             s_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] m_data,
    output logic [$clog2(NUM_INPUTS+1)-1:0]  m_count
);

    localparam int CNT_W = $clog2(NUM_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_INPUTS - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic [CNT_W-1:0]                cnt;
    logic [CNT_W-1:0]                cnt_nxt;
    logic [DATA_WIDTH-1:0]           fill [NUM_INPUTS];
    logic                            accept;
    logic                            complete;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] pack;

    // The output register is free when empty or being drained this cycle.
    assign s_ready  = !m_valid || m_ready;
    assign accept   = s_valid && s_ready;
    assign complete = accept && ((cnt == LAST_LANE) || s_last);

    // FSM state and lane counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: advance the lane on each accepted beat, wrap on completion.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            EMPTY: begin
                if (accept) begin
                    if (complete) begin
                        state_nxt = EMPTY;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = FILL;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    if (complete) begin
                        state_nxt = EMPTY;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = FILL;
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = EMPTY;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Assemble the completed group: stored lanes, the completing sample, zeros above.
    always_comb begin
        pack = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (CNT_W'(i) < cnt) begin
                pack[i*DATA_WIDTH +: DATA_WIDTH] = fill[i];
            end else if (CNT_W'(i) == cnt) begin
                pack[i*DATA_WIDTH +: DATA_WIDTH] = s_data;
            end
        end
    end

    // Fill lanes: store non-completing beats, wipe everything when a group closes.
    always_ff @(posedge clk) begin
        if (rst || complete) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                fill[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (CNT_W'(i) == cnt) begin
                    fill[i] <= s_data;
                end
            end
        end
    end

    // Output register: load on completion, drop valid once consumed, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_count <= '0;
        end else if (complete) begin
            m_valid <= 1'b1;
            m_data  <= pack;
            m_count <= cnt + CNT_W'(1);
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_int_window_packer.sv
// Self-checking bench for int_window_packer: directed scenarios plus a
// randomized run, all checked against a queue-based group model.
module tb_int_window_packer;

    localparam int DW = 32;
    localparam int N  = 9;
    localparam int CW = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [N*DW-1:0]   m_data;
    logic [CW-1:0]     m_count;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: samples of the open group, and the group on the output.
    logic [DW-1:0]     cur [$];
    bit                pend_v;
    logic [N*DW-1:0]   pend_d;
    int                pend_c;

    int_window_packer #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_count (m_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock: apply inputs, report s_ready before the edge, advance the model.
    task automatic drive_cycle(input bit sv, input bit sl, input logic [DW-1:0] sd,
                               input bit mr, input bit r, output bit rdy_obs);
        bit acc;
        s_valid = sv;
        s_last  = sl;
        s_data  = sd;
        m_ready = mr;
        rst     = r;
        #1;
        rdy_obs = s_ready;
        @(posedge clk);
        if (r) begin
            cur.delete();
            pend_v = 0;
            pend_d = '0;
            pend_c = 0;
        end else begin
            acc = sv && (!pend_v || mr);
            if (pend_v && mr) pend_v = 0;
            if (acc) begin
                cur.push_back(sd);
                if (cur.size() == N || sl) begin
                    pend_d = '0;
                    foreach (cur[i]) pend_d[i*DW +: DW] = cur[i];
                    pend_c = cur.size();
                    pend_v = 1;
                    cur.delete();
                end
            end
        end
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        bit rdy;
        drive_cycle(0, 0, '0, 0, 1, rdy);
        drive_cycle(0, 0, '0, 0, 1, rdy);
        n_chk++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else n_pass++;
        n_chk++; if (m_data !== '0) $display("FAIL reset_m_data got %h want 0", m_data); else n_pass++;
        n_chk++; if (m_count !== '0) $display("FAIL reset_m_count got %0d want 0", m_count); else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %b want 1", s_ready); else n_pass++;
    endtask

    task automatic test_full_group();
        bit rdy;
        logic [N*DW-1:0] exp_d;
        longint sum;
        for (int i = 0; i < N; i++) begin
            drive_cycle(1, 0, DW'(i + 1), 1, 0, rdy);
            exp_d[i*DW +: DW] = DW'(i + 1);
            if (i < N - 1) begin
                n_chk++; if (m_valid !== 1'b0) $display("FAIL full_early_valid beat %0d got %b want 0", i, m_valid); else n_pass++;
            end
        end
        n_chk++; if (m_valid !== 1'b1) $display("FAIL full_m_valid got %b want 1", m_valid); else n_pass++;
        n_chk++; if (m_data !== exp_d) $display("FAIL full_m_data got %h want %h", m_data, exp_d); else n_pass++;
        n_chk++; if (m_count !== CW'(9)) $display("FAIL full_m_count got %0d want 9", m_count); else n_pass++;
        sum = 0;
        for (int i = 0; i < N; i++) sum += m_data[i*DW +: DW];
        n_chk++; if (sum != 45) $display("FAIL full_sum got %0d want 45", sum); else n_pass++;
        drive_cycle(0, 0, '0, 1, 0, rdy);
        n_chk++; if (m_valid !== 1'b0) $display("FAIL full_drain got %b want 0", m_valid); else n_pass++;
    endtask

    task automatic test_partial_group();
        bit rdy;
        logic [N*DW-1:0] exp_d;
        exp_d = '0;
        exp_d[0*DW +: DW] = 32'd7;
        exp_d[1*DW +: DW] = 32'd8;
        exp_d[2*DW +: DW] = 32'd9;
        drive_cycle(1, 0, 32'd7, 1, 0, rdy);
        drive_cycle(1, 0, 32'd8, 1, 0, rdy);
        drive_cycle(1, 1, 32'd9, 1, 0, rdy);
        n_chk++; if (m_valid !== 1'b1) $display("FAIL partial_m_valid got %b want 1", m_valid); else n_pass++;
        n_chk++; if (m_count !== CW'(3)) $display("FAIL partial_m_count got %0d want 3", m_count); else n_pass++;
        n_chk++; if (m_data !== exp_d) $display("FAIL partial_m_data got %h want %h", m_data, exp_d); else n_pass++;
        drive_cycle(0, 0, '0, 1, 0, rdy);
    endtask

    task automatic test_backpressure();
        bit rdy;
        logic [N*DW-1:0] grp_a;
        for (int i = 0; i < N; i++) begin
            drive_cycle(1, 0, $urandom, 0, 0, rdy);
        end
        grp_a = pend_d;
        n_chk++; if (m_valid !== 1'b1 || m_data !== grp_a) $display("FAIL bp_group_a got v=%b %h want v=1 %h", m_valid, m_data, grp_a); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 0, $urandom, 0, 0, rdy);
            n_chk++; if (rdy !== 1'b0) $display("FAIL bp_s_ready_low got %b want 0", rdy); else n_pass++;
            n_chk++; if (m_valid !== 1'b1 || m_data !== grp_a || m_count !== CW'(9)) $display("FAIL bp_hold got v=%b c=%0d %h want v=1 c=9 %h", m_valid, m_count, m_data, grp_a); else n_pass++;
        end
        drive_cycle(1, 0, 32'hA5A5_0001, 1, 0, rdy);
        n_chk++; if (rdy !== 1'b1) $display("FAIL bp_release_s_ready got %b want 1", rdy); else n_pass++;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL bp_consumed got %b want 0", m_valid); else n_pass++;
        drive_cycle(1, 1, 32'hA5A5_0002, 1, 0, rdy);
        n_chk++; if (m_valid !== pend_v || m_count !== CW'(pend_c) || m_data !== pend_d) $display("FAIL bp_next_group got v=%b c=%0d %h want v=%b c=%0d %h", m_valid, m_count, m_data, pend_v, pend_c, pend_d); else n_pass++;
        n_chk++; if (m_count !== CW'(2)) $display("FAIL bp_next_count got %0d want 2", m_count); else n_pass++;
        drive_cycle(0, 0, '0, 1, 0, rdy);
    endtask

    task automatic test_back_to_back();
        bit rdy;
        logic [N*DW-1:0] exp_d;
        for (int i = 0; i < 2 * N; i++) begin
            drive_cycle(1, 0, DW'(i), 1, 0, rdy);
            n_chk++; if (rdy !== 1'b1) $display("FAIL b2b_s_ready beat %0d got %b want 1", i, rdy); else n_pass++;
            n_chk++; if (m_valid !== ((i == N - 1) || (i == 2 * N - 1))) $display("FAIL b2b_m_valid beat %0d got %b", i, m_valid); else n_pass++;
            if (i == N - 1 || i == 2 * N - 1) begin
                for (int k = 0; k < N; k++) exp_d[k*DW +: DW] = DW'(i - (N - 1) + k);
                n_chk++; if (m_data !== exp_d || m_count !== CW'(N)) $display("FAIL b2b_group beat %0d got c=%0d %h want c=9 %h", i, m_count, m_data, exp_d); else n_pass++;
            end
        end
        drive_cycle(0, 0, '0, 1, 0, rdy);
    endtask

    task automatic test_reset_mid_group();
        bit rdy;
        logic [N*DW-1:0] exp_d;
        for (int i = 0; i < 4; i++) drive_cycle(1, 0, 32'hDEAD_0000 + DW'(i), 1, 0, rdy);
        drive_cycle(1, 0, 32'hBAD0_BAD0, 1, 1, rdy);
        rst = 1'b0;
        #1;
        n_chk++; if (s_ready !== 1'b1) $display("FAIL rstmid_s_ready got %b want 1", s_ready); else n_pass++;
        for (int i = 0; i < N; i++) begin
            drive_cycle(1, 0, DW'(100 + i), 1, 0, rdy);
            exp_d[i*DW +: DW] = DW'(100 + i);
        end
        n_chk++; if (m_valid !== 1'b1 || m_count !== CW'(9) || m_data !== exp_d) $display("FAIL rstmid_group got v=%b c=%0d %h want v=1 c=9 %h", m_valid, m_count, m_data, exp_d); else n_pass++;
        drive_cycle(0, 0, '0, 1, 0, rdy);
    endtask

    task automatic test_single_sample();
        bit rdy;
        logic [N*DW-1:0] exp_d;
        exp_d = '0;
        exp_d[DW-1:0] = 32'hFFFF_FFFF;
        drive_cycle(1, 1, 32'hFFFF_FFFF, 1, 0, rdy);
        n_chk++; if (m_valid !== 1'b1 || m_count !== CW'(1)) $display("FAIL single_valid_count got v=%b c=%0d want v=1 c=1", m_valid, m_count); else n_pass++;
        n_chk++; if (m_data !== exp_d) $display("FAIL single_m_data got %h want %h", m_data, exp_d); else n_pass++;
        drive_cycle(0, 0, '0, 1, 0, rdy);
    endtask

    task automatic test_random();
        bit rdy, sv, sl, mr;
        for (int c = 0; c < 600; c++) begin
            sv = ($urandom_range(0, 3) != 0);
            sl = ($urandom_range(0, 7) == 0);
            mr = ($urandom_range(0, 2) != 0);
            drive_cycle(sv, sl, $urandom, mr, 0, rdy);
            n_chk++; if (m_valid !== pend_v) $display("FAIL rand_m_valid cycle %0d got %b want %b", c, m_valid, pend_v); else n_pass++;
            if (pend_v) begin
                n_chk++; if (m_count !== CW'(pend_c) || m_data !== pend_d) $display("FAIL rand_group cycle %0d got c=%0d %h want c=%0d %h", c, m_count, m_data, pend_c, pend_d); else n_pass++;
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        pend_v  = 0;
        pend_d  = '0;
        pend_c  = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_full_group();
        test_partial_group();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_group();
        test_single_sample();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/int_window_packer.md
INT_WINDOW_PACKER -- requirements
Module: int_window_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of one integer sample.
REQ-002 SHALL have parameter NUM_INPUTS, default 9, the number of samples per packed group (adder-tree operand count); legal range 2..64.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port s_valid  input  1  upstream sample valid.
REQ-006 SHALL have port s_ready  output  1  the block accepts a sample this cycle.
REQ-007 SHALL have port s_data  input  DATA_WIDTH  upstream sample.
REQ-008 SHALL have port s_last  input  1  this sample ends the group early (partial group).
REQ-009 SHALL have port m_valid  output  1  packed group valid.
REQ-010 SHALL have port m_ready  input  1  downstream consumes the group.
REQ-011 SHALL have port m_data  output  NUM_INPUTS*DATA_WIDTH  packed group; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port m_count  output  $clog2(NUM_INPUTS+1)  number of real samples in m_data (1..NUM_INPUTS).

Function
REQ-013 SHALL accept a sample on a cycle where s_valid and s_ready are both 1; no other cycle changes the fill state.
REQ-014 SHALL drive s_ready = !m_valid || m_ready (combinational; never depends on s_valid or s_last).
REQ-015 SHALL write the k-th accepted sample of a group (k from 0) into fill lane k; the first sample of a group lands in lane 0.
REQ-016 SHALL keep a lane counter cnt, 0..NUM_INPUTS-1, and a state machine with states EMPTY (cnt=0) and FILL (cnt>0).
REQ-017 SHALL complete a group on an accepted beat when cnt==NUM_INPUTS-1 or s_last==1.
REQ-018 On completion SHALL, at the same clock edge: load m_data with the fill lanes including the completing sample; set every lane above the completing lane to zero; set m_count=cnt+1; set m_valid=1; set cnt=0; clear all fill lanes; enter EMPTY.
REQ-019 On a non-completing accepted beat SHALL increment cnt and enter or stay in FILL.
REQ-020 SHALL present a completed group starting the cycle after its completing beat (latency 1 cycle from last accept to m_valid).
REQ-021 SHALL hold m_data, m_count and m_valid stable while m_valid==1 and m_ready==0.
REQ-022 SHALL clear m_valid after a cycle with m_valid && m_ready, unless a new group completes on that same cycle, in which case m_valid stays 1 and m_data/m_count take the new group.
REQ-023 SHALL sustain one accepted sample per cycle while m_ready is held 1.
REQ-024 SHALL treat s_last on the first sample of a group as a group of one (m_count=1, lanes 1..NUM_INPUTS-1 zero).
REQ-025 SHALL pass sample bits unmodified; no sign extension, arithmetic or reordering.
REQ-026 SHALL ignore s_data and s_last on cycles without an accepted beat.

Reset
REQ-027 SHALL, while rst==1 at a clock edge, set cnt=0, state EMPTY, all fill lanes 0, m_valid=0, m_data=0, m_count=0; rst overrides any simultaneous handshake.
REQ-028 SHALL drop any partially filled group when reset is asserted mid-group; the first accepted beat after reset lands in lane 0.
REQ-029 SHALL present s_ready=1 on the first cycle after reset deasserts.

Verification
REQ-030 Full group: defaults, m_ready=1, feed 1..9 on consecutive cycles -> one cycle after the 9th beat m_valid=1, lanes 0..8 = 1..9, m_count=9; adder tree output sums to 45.
REQ-031 Partial group: feed 7,8,9 with s_last on 9 -> m_count=3, lanes 0..2 = 7,8,9, lanes 3..8 = 0.
REQ-032 Backpressure: complete group A with m_ready=0, then offer samples -> s_ready=0, m_data holds A; raise m_ready -> A consumed, s_ready=1 the same cycle.
REQ-033 Back-to-back: m_ready=1, stream 18 samples 0..17 -> two groups on the cycles after beats 8 and 17, contents 0..8 and 9..17, no gap cycles in s_ready.
REQ-034 Reset mid-group: accept 4 samples, pulse rst one cycle, feed 9 samples 100..108 -> one group, lanes 0..8 = 100..108, m_count=9, no trace of the first 4.
REQ-035 Single-sample group: s_last on the first beat, value 0xFFFFFFFF -> m_count=1, lane 0 = 0xFFFFFFFF, all other lanes 0.
